// File: rtl/rv_pkg.sv
// Shared core-wide types and widths used by the rv_top memories.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int NBYTES = 4;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [NBYTES-1:0] be_t;

endpackage

// File: rtl/dff_ram_lane.sv
// One byte column of a write: picks the incoming byte when its enable is set,
// otherwise passes the stored byte through unchanged.
module dff_ram_lane (
  input  logic       we,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] merged
);

  assign merged = we ? new_byte : old_byte;

endmodule

// File: rtl/dff_ram.sv
// Word-addressed, byte-writable single-port flip-flop RAM with registered read.
// Contents are preloaded externally through the visible <inst>.mem array.
module dff_ram
  import rv_pkg::*;
#(
  parameter  int WORDS = 256,
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  be_t           WE,
  input  word_t         Di,
  input  logic [AW-1:0] A,
  output word_t         Do
);

  localparam logic [AW:0] WORDS_W = (AW+1)'(WORDS);

  logic [31:0] mem [0:WORDS-1];

  logic  in_range;
  word_t rd_word;
  word_t wr_word;
  logic  wr_fire;

  // Only non-power-of-two depths can see an address past the end.
  assign in_range = ({1'b0, A} < WORDS_W);
  assign rd_word  = in_range ? mem[A] : '0;
  assign wr_fire  = !RST && EN && in_range && (|WE);

  for (genvar i = 0; i < NBYTES; i++) begin : g_lane
    dff_ram_lane u_lane (
      .we       (WE[i]),
      .old_byte (rd_word[8*i +: 8]),
      .new_byte (Di[8*i +: 8]),
      .merged   (wr_word[8*i +: 8])
    );
  end

  // Do captures the pre-write word, giving read-before-write on a shared address.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Do <= '0;
    end else if (EN) begin
      Do <= rd_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_fire) begin
      mem[A] <= wr_word;
    end
  end

endmodule

// File: tb/tb_dff_ram.sv
// Directed bench for dff_ram: vector table plus hand-written reset and latency sequences.
module tb_dff_ram;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  we;
  logic [31:0] di;
  logic [7:0]  a;
  logic [31:0] dout;

  logic [31:0] exp_q[$];
  int          tests_run;
  int          tests_failed;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [7:0]  a;
    logic [31:0] di;
    logic        chk;
    logic [31:0] exp_do;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  dff_ram #(.WORDS(256)) dut (
    .CLK (clk),
    .RST (rst),
    .EN  (en),
    .WE  (we),
    .Di  (di),
    .A   (a),
    .Do  (dout)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic r, input logic e, input logic [3:0] w,
                       input logic [7:0] addr, input logic [31:0] d);
    @(negedge clk);
    rst = r;
    en  = e;
    we  = w;
    a   = addr;
    di  = d;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  task automatic check(input string name);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    tests_run++;
    if (dout !== exp) begin
      tests_failed++;
      $display("FAIL %s: Do=%h expected %h", name, dout, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; en = 1'b1; we = 4'h0; a = 8'd0; di = 32'h0;

    //            en  we     a      di            chk  exp_do
    vecs[0]  = '{1'b1, 4'hF, 8'd0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 4'hF, 8'd1, 32'h00000111, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 4'hF, 8'd2, 32'h00000222, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 4'hF, 8'd3, 32'h00500093, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 4'hF, 8'd5, 32'h11223344, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 4'hF, 8'd7, 32'h00000000, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 4'hF, 8'd9, 32'h13579BDF, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 4'h0, 8'd3, 32'h0,        1'b1, 32'h00500093};
    vecs[8]  = '{1'b1, 4'h5, 8'd5, 32'hAABBCCDD, 1'b1, 32'h11223344};
    vecs[9]  = '{1'b1, 4'h0, 8'd5, 32'h0,        1'b1, 32'h11BB33DD};
    vecs[10] = '{1'b1, 4'hF, 8'd7, 32'hCAFEF00D, 1'b1, 32'h00000000};
    vecs[11] = '{1'b1, 4'h0, 8'd7, 32'h0,        1'b1, 32'hCAFEF00D};
    vecs[12] = '{1'b0, 4'hF, 8'd9, 32'hFFFFFFFF, 1'b1, 32'hCAFEF00D};
    vecs[13] = '{1'b1, 4'h0, 8'd9, 32'h0,        1'b1, 32'h13579BDF};
    vecs[14] = '{1'b1, 4'h0, 8'd0, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[15] = '{1'b1, 4'h0, 8'd1, 32'h0,        1'b1, 32'h00000111};
    vecs[16] = '{1'b1, 4'h0, 8'd2, 32'h0,        1'b1, 32'h00000222};
    vecs[17] = '{1'b1, 4'h0, 8'd3, 32'h0,        1'b1, 32'h00500093};
    vecs[18] = '{1'b1, 4'hA, 8'd9, 32'hAABBCCDD, 1'b1, 32'h13579BDF};
    vecs[19] = '{1'b1, 4'h0, 8'd9, 32'h0,        1'b1, 32'hAA57CCDF};
    vecs[20] = '{1'b0, 4'h0, 8'd0, 32'h0,        1'b1, 32'hAA57CCDF};

    // Power-on reset: two edges with EN high, Do must be zero.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 4'h0, 8'd0, 32'h0);
      edge_sample();
      exp_q.push_back(32'h0);
      check($sformatf("por_reset%0d", i));
    end

    // Table-driven vectors.
    for (int i = 0; i < NVEC; i++) begin
      drive(1'b0, vecs[i].en, vecs[i].we, vecs[i].a, vecs[i].di);
      edge_sample();
      if (vecs[i].chk) begin
        exp_q.push_back(vecs[i].exp_do);
        check($sformatf("vec%0d", i));
      end
    end

    // Reset with a write pending at A=0: Do cleared, write dropped.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 4'hF, 8'd0, 32'h12345678);
      edge_sample();
      exp_q.push_back(32'h0);
      check($sformatf("rst_mid_write%0d", i));
    end

    // Read latency: Do stays at reset value until the edge after A is applied.
    drive(1'b0, 1'b1, 4'h0, 8'd3, 32'h0);
    #1;
    exp_q.push_back(32'h0);
    check("latency_before_edge");
    edge_sample();
    exp_q.push_back(32'h00500093);
    check("latency_after_edge");

    // mem[0] survived both the reset and the suppressed write.
    drive(1'b0, 1'b1, 4'h0, 8'd0, 32'h0);
    edge_sample();
    exp_q.push_back(32'hDEADBEEF);
    check("mem0_after_reset");

    // Single-lane write on the top byte, then read back.
    drive(1'b0, 1'b1, 4'h8, 8'd0, 32'h55000000);
    edge_sample();
    exp_q.push_back(32'hDEADBEEF);
    check("lane3_rdw");
    drive(1'b0, 1'b1, 4'h0, 8'd0, 32'h0);
    edge_sample();
    exp_q.push_back(32'h55ADBEEF);
    check("lane3_readback");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
